// File: rtl/bch_pkg.sv
// Shared BCH definitions: FSM state encoding and generator polynomials.
// Pure declarations; no timing or flow-control behaviour.
package bch_pkg;

    typedef enum logic {
        ST_MSG = 1'b0,
        ST_PAR = 1'b1
    } bch_state_e;

    localparam logic [8:0]  GEN_POLY_15_7 = 9'h1D1;
    localparam logic [10:0] GEN_POLY_15_5 = 11'h537;
    // Production code: x^16 + x^5 + x^3 + x^2 + 1, 16 parity bits.
    localparam logic [16:0] GEN_POLY_PROD = 17'h1_002D;

endpackage

// File: rtl/bch_enc_par_lfsr_step.sv
// PARALLELISM unrolled LFSR division steps on the remainder, MSB of dat_in first.
// Purely combinational: zero latency, no flow control.
module bch_lfsr_step #(
    parameter int                   PARALLELISM = 16,
    parameter int                   PARITY_BITS = 16,
    parameter logic [PARITY_BITS:0] GEN_POLY    = bch_pkg::GEN_POLY_PROD
) (
    input  logic [PARITY_BITS-1:0] rem_in,
    input  logic [PARALLELISM-1:0] dat_in,
    output logic [PARITY_BITS-1:0] rem_out
);

    logic [PARITY_BITS-1:0] r;
    logic                   fb;

    always_comb begin
        r  = rem_in;
        fb = 1'b0;
        for (int i = PARALLELISM - 1; i >= 0; i--) begin
            fb = dat_in[i] ^ r[PARITY_BITS-1];
            r  = {r[PARITY_BITS-2:0], 1'b0} ^ (fb ? GEN_POLY[PARITY_BITS-1:0] : '0);
        end
        rem_out = r;
    end

endmodule

// File: rtl/bch_enc_par.sv
// Systematic parallel BCH encoder: message beats pass through, then parity; 1-cycle latency.
// Single output register stalls on !out_ready; in_ready is low while parity drains.
module bch_enc_par
    import bch_pkg::*;
#(
    parameter int                   PARALLELISM = 16,
    parameter int                   MSG_BITS    = 1008,
    parameter int                   PARITY_BITS = 16,
    parameter logic [PARITY_BITS:0] GEN_POLY    = GEN_POLY_PROD
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PARALLELISM-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PARALLELISM-1:0] out_data,
    output logic                   out_parity,
    output logic                   out_last
);

    localparam int MSG_BEATS = MSG_BITS / PARALLELISM;
    localparam int PAR_BEATS = PARITY_BITS / PARALLELISM;
    localparam int CNT_W     = (MSG_BEATS > 1) ? $clog2(MSG_BEATS) : 1;
    localparam int PCNT_W    = $clog2(PAR_BEATS + 1);

    bch_state_e             state_q, state_d;
    logic [PARITY_BITS-1:0] rem_q, rem_d, rem_step;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PCNT_W-1:0]      pcnt_q, pcnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [PARALLELISM-1:0] out_data_q, out_data_d;
    logic                   out_parity_q, out_parity_d;
    logic                   out_last_q, out_last_d;

    logic out_hs;
    logic out_free;
    logic in_acc;

    bch_lfsr_step #(
        .PARALLELISM (PARALLELISM),
        .PARITY_BITS (PARITY_BITS),
        .GEN_POLY    (GEN_POLY)
    ) u_step (
        .rem_in  (rem_q),
        .dat_in  (in_data),
        .rem_out (rem_step)
    );

    assign out_hs   = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == ST_MSG) && out_free;
    assign in_acc   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        pcnt_d       = pcnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;
        out_last_d   = out_last_q;

        if (out_hs) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_MSG: begin
                if (in_acc) begin
                    out_data_d   = in_data;
                    out_valid_d  = 1'b1;
                    out_parity_d = 1'b0;
                    out_last_d   = 1'b0;
                    rem_d        = rem_step;
                    if (cnt_q == CNT_W'(MSG_BEATS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_PAR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PAR: begin
                if (out_hs && out_last_q) begin
                    state_d      = ST_MSG;
                    rem_d        = '0;
                    cnt_d        = '0;
                    pcnt_d       = '0;
                    out_parity_d = 1'b0;
                    out_last_d   = 1'b0;
                end else if (out_free && (pcnt_q != PCNT_W'(PAR_BEATS))) begin
                    // The remainder is shifted as each parity beat enters the output register.
                    out_data_d   = rem_q[PARITY_BITS-1 -: PARALLELISM];
                    out_valid_d  = 1'b1;
                    out_parity_d = 1'b1;
                    out_last_d   = (pcnt_q == PCNT_W'(PAR_BEATS - 1));
                    rem_d        = rem_q << PARALLELISM;
                    pcnt_d       = pcnt_q + PCNT_W'(1);
                end
            end
            default: state_d = ST_MSG;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_MSG;
            rem_q        <= '0;
            cnt_q        <= '0;
            pcnt_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            pcnt_q       <= pcnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_bch_enc_par.sv
// Bench for bch_enc_par: BCH(15,7) bit-serial instance and BCH(15,5) 5-bit instance,
// scoreboarded against polynomial long division.
module tb_bch_enc_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_parity, a_out_last;
    logic [0:0] a_in_data, a_out_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_parity, b_out_last;
    logic [4:0] b_in_data, b_out_data;

    bch_enc_par #(.PARALLELISM(1), .MSG_BITS(7), .PARITY_BITS(8), .GEN_POLY(9'h1D1)) dut_a (
        .clk(clk), .rstn(rstn),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_parity(a_out_parity), .out_last(a_out_last)
    );

    bch_enc_par #(.PARALLELISM(5), .MSG_BITS(5), .PARITY_BITS(10), .GEN_POLY(11'h537)) dut_b (
        .clk(clk), .rstn(rstn),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_parity(b_out_parity), .out_last(b_out_last)
    );

    int checks = 0;
    int errors = 0;
    int a_mode = 0;
    int b_mode = 0;

    typedef struct packed {
        logic [15:0] dat;
        logic        par;
        logic        last;
    } beat_t;

    beat_t a_q[$];
    beat_t b_q[$];

    // Remainder of a(x) mod g(x), where a has degree <= hi and g has degree r.
    function automatic logic [31:0] poly_rem(input logic [31:0] a, input int hi,
                                             input logic [31:0] g, input int r);
        logic [31:0] x;
        x = a;
        for (int i = hi; i >= r; i--)
            if (x[i]) x = x ^ (g << (i - r));
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic a_push(input logic [6:0] msg);
        logic [31:0] p;
        beat_t       e;
        p = poly_rem(32'(msg) << 8, 14, 32'h1D1, 8);
        for (int i = 6; i >= 0; i--) begin
            e.dat = 16'(msg[i]); e.par = 1'b0; e.last = 1'b0;
            a_q.push_back(e);
        end
        for (int i = 7; i >= 0; i--) begin
            e.dat = 16'(p[i]); e.par = 1'b1; e.last = (i == 0);
            a_q.push_back(e);
        end
    endtask

    task automatic b_push(input logic [4:0] msg);
        logic [31:0] p;
        beat_t       e;
        p = poly_rem(32'(msg) << 10, 14, 32'h537, 10);
        e.dat = 16'(msg);     e.par = 1'b0; e.last = 1'b0; b_q.push_back(e);
        e.dat = 16'(p[9:5]);  e.par = 1'b1; e.last = 1'b0; b_q.push_back(e);
        e.dat = 16'(p[4:0]);  e.par = 1'b1; e.last = 1'b1; b_q.push_back(e);
    endtask

    // Offers nbeats beats of msg, MSB first; returns #1 after the last accepting edge.
    task automatic a_send(input logic [6:0] msg, input int nbeats);
        logic acc;
        int   guard;
        for (int i = 0; i < nbeats; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = msg[6-i];
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 200) begin
                @(negedge clk);
                acc = a_in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) check("a_accept_timeout", 32'(guard), 32'd0);
            if (i == 0) check("a_latency_valid", 32'(a_out_valid), 32'd1);
        end
        a_in_valid = 1'b0;
    endtask

    task automatic b_send(input logic [4:0] msg);
        logic acc;
        int   guard;
        b_in_valid = 1'b1;
        b_in_data  = msg;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = b_in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("b_accept_timeout", 32'(guard), 32'd0);
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input int which);
        int guard;
        guard = 0;
        while (((which == 0) ? a_q.size() : b_q.size()) != 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 1000) check("drain_timeout", 32'(guard), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_out_ready = (a_mode == 0) ? 1'b1 : (a_mode == 1) ? ~a_out_ready : 1'($urandom_range(0, 1));
            b_out_ready = (b_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 6);
        end
    end

    logic       a_prev_stall = 1'b0;
    logic [0:0] a_prev_dat   = '0;
    always @(negedge clk) begin
        beat_t e;
        if (rstn) begin
            if (a_prev_stall) begin
                check("a_stall_valid", 32'(a_out_valid), 32'd1);
                check("a_stall_data", 32'(a_out_data), 32'(a_prev_dat));
            end
            if (a_out_valid && a_out_parity) check("a_in_ready_in_par", 32'(a_in_ready), 32'd0);
            if (a_out_valid && a_out_ready) begin
                if (a_q.size() == 0) begin
                    check("a_unexpected_beat", 32'(a_out_data), 32'hFFFF);
                end else begin
                    e = a_q.pop_front();
                    check("a_data", 32'(a_out_data), 32'(e.dat));
                    check("a_parity_flag", 32'(a_out_parity), 32'(e.par));
                    check("a_last", 32'(a_out_last), 32'(e.last));
                end
            end
            a_prev_stall <= a_out_valid && !a_out_ready;
            a_prev_dat   <= a_out_data;
        end else begin
            a_prev_stall <= 1'b0;
        end
    end

    logic        b_prev_stall = 1'b0;
    logic [4:0]  b_prev_dat   = '0;
    logic [14:0] b_cw         = '0;
    always @(negedge clk) begin
        beat_t       e;
        logic [14:0] nxt;
        if (rstn) begin
            if (b_prev_stall) check("b_stall_data", 32'(b_out_data), 32'(b_prev_dat));
            if (b_out_valid && b_out_ready) begin
                nxt = {b_cw[9:0], b_out_data};
                b_cw <= nxt;
                if (b_q.size() == 0) begin
                    check("b_unexpected_beat", 32'(b_out_data), 32'hFFFF);
                end else begin
                    e = b_q.pop_front();
                    check("b_data", 32'(b_out_data), 32'(e.dat));
                    check("b_parity_flag", 32'(b_out_parity), 32'(e.par));
                    check("b_last", 32'(b_out_last), 32'(e.last));
                end
                if (b_out_last) check("b_codeword_rem", poly_rem(32'(nxt), 14, 32'h537, 10), 32'd0);
            end
            b_prev_stall <= b_out_valid && !b_out_ready;
            b_prev_dat   <= b_out_data;
        end else begin
            b_prev_stall <= 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_idle(input string tag);
        check({tag, "_a_out_valid"}, 32'(a_out_valid), 32'd0);
        check({tag, "_a_out_data"}, 32'(a_out_data), 32'd0);
        check({tag, "_a_in_ready"}, 32'(a_in_ready), 32'd1);
        check({tag, "_a_out_parity"}, 32'(a_out_parity), 32'd0);
        check({tag, "_a_out_last"}, 32'(a_out_last), 32'd0);
        check({tag, "_b_out_valid"}, 32'(b_out_valid), 32'd0);
        check({tag, "_b_in_ready"}, 32'(b_in_ready), 32'd1);
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(a_out_valid), 32'd0);
        check("async_rst_in_ready", 32'(a_in_ready), 32'd1);
        a_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pseen;
        int guard;
        logic [4:0] m;
        rstn = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0;
        b_in_valid = 1'b0; b_in_data = '0;
        #3;
        check_idle("reset");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("post_release");

        // Single codeword.
        a_push(7'b0000001); a_send(7'b0000001, 7); drain(0);

        // Back-to-back codewords with in_valid held high.
        a_push(7'b0000011); a_send(7'b0000011, 7);
        a_push(7'b0000010); a_send(7'b0000010, 7);
        drain(0);

        // Alternating out_ready.
        a_mode = 1;
        a_push(7'b0000001); a_send(7'b0000001, 7); drain(0);
        a_mode = 2;
        for (int n = 0; n < 20; n++) begin
            m = 5'($urandom);
            a_push({2'($urandom), m}); a_send({a_q[a_q.size()-15].dat[0], a_q[a_q.size()-14].dat[0],
                   a_q[a_q.size()-13].dat[0], a_q[a_q.size()-12].dat[0], a_q[a_q.size()-11].dat[0],
                   a_q[a_q.size()-10].dat[0], a_q[a_q.size()-9].dat[0]}, 7);
        end
        drain(0);
        a_mode = 0;

        // Reset after four message beats, then a fresh codeword.
        a_push(7'b1011001); a_send(7'b1011001, 4);
        pulse_reset();
        a_push(7'b0000001); a_send(7'b0000001, 7); drain(0);

        // Reset while the third parity beat is presented.
        a_push(7'b1110101); a_send(7'b1110101, 7);
        pseen = 0;
        guard = 0;
        while (pseen < 3 && guard < 100) begin
            @(negedge clk);
            if (a_out_valid && a_out_parity) pseen++;
            guard++;
        end
        if (pseen < 3) check("a_parity_wait_timeout", 32'(pseen), 32'd3);
        #2;
        pulse_reset();
        a_push(7'b0000001); a_send(7'b0000001, 7); drain(0);

        // 5-bit configuration: all-zero, all-one, then random messages under random backpressure.
        b_push(5'h00); b_send(5'h00);
        b_push(5'h1F); b_send(5'h1F);
        b_mode = 2;
        for (int n = 0; n < 1000; n++) begin
            m = 5'($urandom);
            b_push(m);
            b_send(m);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain(1);

        check("a_queue_empty", 32'(a_q.size()), 32'd0);
        check("b_queue_empty", 32'(b_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bch_enc_par.md
BCH_ENC_PAR -- requirements
Module: bch_enc_par

Interface
REQ-001 SHALL have parameter PARALLELISM, default 16: bits per beat on both ports.
REQ-002 SHALL have parameter MSG_BITS, default 1008: message length k in bits; must be a multiple of PARALLELISM.
REQ-003 SHALL have parameter PARITY_BITS, default 16: parity length n-k in bits; must be a multiple of PARALLELISM.
REQ-004 SHALL have parameter GEN_POLY, default from the shared package, width PARITY_BITS+1: generator g(x); bit i is the coefficient of x^i, and the MSB is 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: message beat present.
REQ-008 SHALL have port in_ready, output, 1 bit: beat accepted when in_valid && in_ready at the clock edge.
REQ-009 SHALL have port in_data, input, PARALLELISM bits: message bits; the MSB is the earliest (highest-degree) bit.
REQ-010 SHALL have port out_valid, output, 1 bit: codeword beat present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts when out_valid && out_ready.
REQ-012 SHALL have port out_data, output, PARALLELISM bits: codeword bits, MSB first.
REQ-013 SHALL have port out_parity, output, 1 bit: the current out beat is parity.
REQ-014 SHALL have port out_last, output, 1 bit: the current out beat is the final parity beat of a codeword.

Function
REQ-015 SHALL produce a systematic codeword: MSG_BITS/PARALLELISM message beats unchanged, then PARITY_BITS/PARALLELISM parity beats equal to (m(x)·x^PARITY_BITS) mod g(x), MSB first.
REQ-016 SHALL use an FSM with states MSG and PAR; the reset state is MSG.
REQ-017 SHALL, in MSG, drive in_ready = !out_valid || out_ready.
REQ-018 SHALL, in PAR, drive in_ready = 0.
REQ-019 SHALL, on an accepted input beat, load in_data into the output register, set out_valid=1 and out_parity=0, and update the PARITY_BITS-bit remainder register by PARALLELISM unrolled LFSR steps in the same cycle.
REQ-020 SHALL implement each LFSR step, per bit d, as: fb = d ^ r[MSB]; r = (r<<1) ^ (fb ? GEN_POLY[PARITY_BITS-1:0] : 0).
REQ-021 SHALL have a latency of 1 cycle from input accept to out_valid; throughput in MSG SHALL be one beat per cycle under continuous out_ready.
REQ-022 SHALL keep out_data/out_valid stable while out_valid && !out_ready.
REQ-023 SHALL allow a simultaneous out handshake and new input accept in the same cycle, with no bubble.
REQ-024 SHALL count message beats with a wrap-around counter; when the last message beat is accepted, the state SHALL be PAR on the next cycle.
REQ-025 SHALL, in PAR, present the remainder's top PARALLELISM bits with out_parity=1 whenever the output register is free, and shift the remainder left by PARALLELISM on each out handshake.
REQ-026 SHALL assert out_last on the final parity beat.
REQ-027 SHALL, on the out_last handshake, clear the remainder and the counters and return to MSG; the next input is accepted no earlier than the following cycle.
REQ-028 SHALL treat in_valid during PAR as no effect; data is held upstream.
REQ-029 SHALL give an all-zero message all-zero parity.

Reset
REQ-030 SHALL, on rstn low, asynchronously clear immediately: state=MSG, remainder=0, counters=0, out_valid=0, out_data=0, out_parity=0, out_last=0.
REQ-031 SHALL drive in_ready=1 after reset.
REQ-032 SHALL discard any partial codeword on a reset mid-codeword; the first beat accepted after release starts a new codeword.

Structure
REQ-033 SHALL take the state encoding constants and the default GEN_POLY values (BCH(15,7): 9'h1D1; BCH(15,5): 11'h537; production code) from the shared bch package header.
REQ-034 SHALL place the combinational PARALLELISM-step remainder update in sub-module bch_lfsr_step (parameters PARALLELISM, PARITY_BITS, GEN_POLY).

Verification (bench parameters: PARALLELISM=1, MSG_BITS=7, PARITY_BITS=8, GEN_POLY=9'h1D1 unless stated)
REQ-035 SHALL verify reset: rstn low -> out_valid=0, out_data=0, in_ready=1; then rstn high with no stimulus -> outputs unchanged.
REQ-036 SHALL verify a single codeword: message 0000001 -> out 0000001 then parity 11010001 (8'hD1), out_last on the 15th beat.
REQ-037 SHALL verify back-to-back codewords: message 0000011 then 0000010, in_valid always high -> parity 8'hA2 then 8'h73, in_ready low exactly during the parity beats.
REQ-038 SHALL verify backpressure: message 0000001 with out_ready toggling 1010... -> identical codeword, no lost or duplicated beat, out_data stable while stalled.
REQ-039 SHALL verify reset mid-operation: rstn pulsed after 4 message beats (and again during the 3rd parity beat) -> a fresh 0000001 codeword still yields 8'hD1.
REQ-040 SHALL verify the 5-bit configuration: PARALLELISM=5, MSG_BITS=5, PARITY_BITS=10, GEN_POLY=11'h537 -> 1000 random messages match a software polynomial-division model, and every 15-bit codeword has zero remainder mod g(x).
